// File: rtl/channel_sequencer_pkg.sv
// rtl/channel_sequencer_pkg.sv - shared constants, state type and helpers for the channel sequencer
package channel_seq_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Index of the lowest set bit; 0 for an empty mask (callers reject empty masks first).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/channel_sequencer_if.sv
// rtl/channel_sequencer_if.sv - control and decoder-select bundle for the channel sequencer
interface channel_sequencer_if #(
    parameter int DWELL_W = 8
) ();

    logic                                 start;
    logic                                 stop;
    logic                                 hold;
    logic                                 one_shot;
    logic [channel_seq_pkg::NUM_CH-1:0]   mask;
    logic [DWELL_W-1:0]                   dwell;
    logic [channel_seq_pkg::SEL_W-1:0]    sel;
    logic                                 sel_valid;
    logic                                 step;
    logic                                 busy;
    logic                                 done;
    logic                                 err_empty;

    modport master (
        output start, stop, hold, one_shot, mask, dwell,
        input  sel, sel_valid, step, busy, done, err_empty
    );

    modport slave (
        input  start, stop, hold, one_shot, mask, dwell,
        output sel, sel_valid, step, busy, done, err_empty
    );

endinterface

// File: rtl/next_index_finder.sv
// rtl/next_index_finder.sv - combinational search for the next set mask bit cyclically above cur
module next_index_finder
    import channel_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next_idx,
    output logic              wrap
);

    logic [SEL_W-1:0] cand;

    // Scan farthest-first so the nearest set bit above cur is the last one written;
    // offset NUM_CH lands back on cur itself, covering the single-bit mask.
    always_comb begin
        next_idx = cur;
        cand     = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = cur + SEL_W'(i);
            if (mask[cand]) next_idx = cand;
        end
        wrap = (next_idx <= cur);
    end

endmodule

// File: rtl/channel_sequencer.sv
// rtl/channel_sequencer.sv - walks enabled channels in ascending order with a programmable dwell
module channel_sequencer
    import channel_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    channel_sequencer_if.slave  bus
);

    seq_state_e          state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                valid_q, valid_d;
    logic                step_q, step_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                os_q, os_d;
    logic [SEL_W-1:0]    next_idx;
    logic                next_wrap;

    next_index_finder u_next (
        .mask     (mask_q),
        .cur      (sel_q),
        .next_idx (next_idx),
        .wrap     (next_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            os_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            os_q    <= os_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        os_d    = os_q;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (bus.start && !bus.stop) begin
                    if (bus.mask != '0) begin
                        mask_d  = bus.mask;
                        dwell_d = bus.dwell;
                        os_d    = bus.one_shot;
                        sel_d   = lowest_set(bus.mask);
                        cnt_d   = bus.dwell;
                        step_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (bus.hold) begin
                    cnt_d = cnt_q;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (next_wrap && os_q) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    // On a continuous wrap next_idx already is the lowest set bit.
                    sel_d  = next_idx;
                    cnt_d  = dwell_q;
                    step_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = valid_q;
    assign bus.step      = step_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.err_empty = err_q;

endmodule

// File: tb/tb_channel_sequencer.sv
// tb/tb_channel_sequencer.sv - randomized self-checking bench for channel_sequencer
module tb_channel_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    channel_sequencer_if #(.DWELL_W(8)) bus ();

    channel_sequencer #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observation word: {sel[8:5], sel_valid[4], step[3], busy[2], done[1], err_empty[0]}
    function automatic logic [8:0] obs();
        return {bus.sel, bus.sel_valid, bus.step, bus.busy, bus.done, bus.err_empty};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.one_shot = 1'b0;
        bus.mask = '0; bus.dwell = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if (obs() !== 9'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", obs(), 9'h000);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs() !== 9'h000) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", obs(), 9'h000);
        end
    endtask

    // Expected trace: each enabled channel ascending, held dwell+1 cycles, step on its first
    // cycle. A held edge repeats the current cycle without step. Start/mask noise during RUN
    // must be ignored.
    task automatic run_scan(input logic [15:0] m, input logic [7:0] d, input logic os,
                            input int ncyc, input int hold_pct, input string name);
        logic [8:0] q[$];
        logic [8:0] cur, exp;
        logic [3:0] last;
        logic       h;
        int         n;
        last = '0;
        do begin
            for (int b = 0; b < 16; b++) begin
                if (m[b]) begin
                    for (int k = 0; k <= int'(d); k++)
                        q.push_back({b[3:0], 1'b1, (k == 0), 1'b1, 1'b0, 1'b0});
                    last = b[3:0];
                end
            end
        end while (!os && q.size() < ncyc + 1);
        if (os) begin
            q.push_back({last, 5'b00010});
            q.push_back({last, 5'b00000});
        end
        bus.mask = m; bus.dwell = d; bus.one_shot = os; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cur = q.pop_front();
        checks++;
        if (obs() !== cur) begin
            failures++;
            $display("FAIL %s_first: got %h expected %h", name, obs(), cur);
        end
        n = 0;
        while (q.size() > 0 && (os || n < ncyc)) begin
            h = cur[2] && ($urandom_range(99) < hold_pct);
            bus.hold = h;
            bus.start = cur[2] && ($urandom_range(5) == 0);
            if (bus.start) begin
                bus.mask = 16'hFFFF ^ 16'($urandom_range(3));
                bus.dwell = 8'($urandom);
                bus.one_shot = 1'($urandom);
            end
            tick();
            bus.start = 1'b0;
            exp = h ? (cur & 9'h1F7) : q.pop_front();
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL %s_cycle%0d: got %h expected %h", name, n, obs(), exp);
            end
            cur = exp;
            n++;
        end
        bus.hold = 1'b0;
        if (!os) begin
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            exp = {cur[8:5], 5'b00000};
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL %s_stop: got %h expected %h", name, obs(), exp);
            end
        end
    endtask

    task automatic test_empty();
        do_reset();
        bus.mask = '0; bus.dwell = 8'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (obs() !== 9'h001) begin
            failures++;
            $display("FAIL empty_err: got %h expected %h", obs(), 9'h001);
        end
        tick();
        checks++;
        if (obs() !== 9'h000) begin
            failures++;
            $display("FAIL empty_after: got %h expected %h", obs(), 9'h000);
        end
    endtask

    task automatic test_start_stop();
        do_reset();
        bus.mask = 16'hFFFF; bus.start = 1'b1; bus.stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== 9'h000) begin
                failures++;
                $display("FAIL start_stop_c%0d: got %h expected %h", i, obs(), 9'h000);
            end
        end
        clear_inputs();
    endtask

    task automatic test_stop_mid();
        int  i;
        do_reset();
        bus.mask = 16'h00F0; bus.dwell = 8'd3; bus.one_shot = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        i = 0;
        while (!(bus.sel == 4'd5 && bus.sel_valid) && i < 40) begin
            tick();
            i++;
        end
        checks++;
        if (i >= 40) begin
            failures++;
            $display("FAIL stop_mid_timeout: got sel %0d expected 5", bus.sel);
        end else begin
            bus.stop = 1'b1; bus.hold = 1'b1;
            tick();
            bus.stop = 1'b0; bus.hold = 1'b0;
            if (obs() !== {4'd5, 5'b00000}) begin
                failures++;
                $display("FAIL stop_mid: got %h expected %h", obs(), {4'd5, 5'b00000});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.mask = 16'h00F0; bus.dwell = 8'd5; bus.one_shot = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        checks++;
        if (obs() !== {4'd4, 5'b10100}) begin
            failures++;
            $display("FAIL reset_mid_running: got %h expected %h", obs(), {4'd4, 5'b10100});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 9'h000) begin
            failures++;
            $display("FAIL reset_mid_async: got %h expected %h", obs(), 9'h000);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (obs() !== 9'h000) begin
            failures++;
            $display("FAIL reset_mid_restart: got %h expected %h", obs(), 9'h000);
        end
    endtask

    task automatic test_random();
        logic [15:0] m;
        for (int t = 0; t < 20; t++) begin
            m = 16'($urandom);
            if (m == '0) m = 16'h0001 << $urandom_range(15);
            if ($urandom_range(3) == 0) m = 16'h0001 << $urandom_range(15);
            run_scan(m, 8'($urandom_range(4)), 1'($urandom), 25, 20, "random");
        end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_empty();
        do_reset();
        run_scan(16'h0005, 8'd2, 1'b1, 0, 0, "oneshot_0005");
        run_scan(16'h8001, 8'd0, 1'b0, 12, 0, "alt_8001");
        run_scan(16'h0010, 8'd3, 1'b0, 30, 40, "hold_0010");
        run_scan(16'h0100, 8'd255, 1'b1, 0, 0, "max_dwell");
        run_scan(16'h0180, 8'd1, 1'b0, 16, 0, "wrap_0180");
        test_stop_mid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_sequencer.md
# channel_sequencer

Programmable channel scanner that sits directly upstream of the 4-to-16 one-hot decoder. It walks the set bits of a 16-bit enable mask in ascending order and holds each channel index for a programmable dwell time. It drives a 4-bit binary select plus a valid qualifier into the decoder. It supports one-shot and continuous (wrapping) scans, pause, and abort.

## Interface
- DWELL_W, 8, width of the dwell count; each channel is held for dwell+1 cycles.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; sampled in every state.
- hold  input  1  freeze the dwell counter while in RUN.
- one_shot  input  1  1 = single ascending pass, 0 = continuous wrap; latched at start.
- mask  input  16  channel enable mask; latched at start.
- dwell  input  DWELL_W  dwell count; latched at start.
- sel  output  4  current channel index; feeds the decoder input.
- sel_valid  output  1  sel is active (high throughout RUN).
- step  output  1  one-cycle pulse coincident with every new sel load, including the first.
- busy  output  1  state == RUN.
- done  output  1  one-cycle pulse when a one-shot pass completes.
- err_empty  output  1  one-cycle pulse when start is sampled with mask == 0.

## Operation
- States: IDLE and RUN.
- Reset (rst_n low, async): state=IDLE; sel=0; sel_valid=0; step=0; busy=0; done=0; err_empty=0; dwell counter=0; latched registers=0.
- IDLE, start=1, stop=0, mask!=0:
  - latch mask, dwell and one_shot;
  - sel <= lowest set bit of the input mask; step=1; counter <= dwell;
  - go to RUN.
- IDLE, start=1, stop=0, mask==0: err_empty=1 for one cycle; stay in IDLE.
- IDLE, start=1, stop=1: stop wins; no action, no pulses.
- RUN, stop=1: go to IDLE next edge.
  - sel_valid=0; sel keeps its last value.
  - No done pulse. stop has priority over hold and over advance.
- RUN, hold=1, stop=0: counter, sel and state are frozen; step=0.
- RUN, counter != 0, no hold: counter decrements by 1.
- RUN, counter == 0, no hold: advance. "Next" is the next set bit of the latched mask above sel, cyclically.
  - No wrap: sel <= next; counter <= latched dwell; step=1.
  - Wrap (sel is the highest set bit), one_shot=0: sel <= lowest set bit; reload counter; step=1.
  - Wrap, one_shot=1: go to IDLE; sel_valid=0; done=1 for one cycle; sel keeps its last value.
- Single-bit mask in continuous mode: the same index is re-selected each period and step pulses every dwell+1 cycles.
- start in RUN is ignored. Changes to mask, dwell or one_shot during RUN have no effect until the next start.
- Counter arithmetic is unsigned DWELL_W bits. A dwell of 2^DWELL_W-1 gives 2^DWELL_W cycles per channel.

## Timing
- start sampled at edge k: sel, sel_valid and step are valid after edge k (cycle k+1). Latency is one cycle.
- There is no gap cycle between channels. sel_valid stays continuously high across advances and wraps.
- All outputs are registered; none are combinational from inputs.
- done and err_empty are single-cycle pulses, each asserted in the cycle after the causing edge.
- Reset deasserting mid-operation: the block restarts in IDLE and needs a fresh start.

## Structure
- Package channel_seq_pkg holds:
  - NUM_CH=16 and SEL_W=4;
  - the state enum (IDLE, RUN);
  - a function lowest_set(mask) returning a 4-bit index.
- Sub-module next_index_finder is combinational.
  - Inputs: 16-bit mask and 4-bit current index.
  - Outputs: the next set index cyclically above current, and a wrap flag.
  - wrap=1 when the next index is <= current, including the single-bit case.
- The top level contains the FSM, the dwell counter, the latch registers and the pulse registers.

## Test plan
- mask=0x0005, dwell=2, one_shot=1, start in cycle 0:
  - sel=0 with step in cycle 1; sel=0 valid in cycles 1-3;
  - sel=2 with step in cycle 4; sel=2 valid in cycles 4-6;
  - cycle 7: sel_valid=0, done=1, busy=0, sel=2.
- mask=0x8001, dwell=0, one_shot=0: sel alternates 0,15,0,15 every cycle; step is high every cycle; done is never asserted.
- mask=0x0000, start: err_empty=1 for exactly one cycle; busy, sel_valid and step stay 0.
- mask=0x0010, dwell=3, continuous:
  - hold high for 5 cycles in mid-dwell extends that period from 4 to 9 cycles;
  - step pulses only at each reload.
- Scan running on mask=0x00F0:
  - stop sampled while sel=5 gives sel_valid=0 next cycle, sel=5 retained, done=0;
  - a second run asserting rst_n low mid-dwell immediately zeroes all outputs.
- start and stop together in IDLE: no activity.
- start re-asserted during RUN with mask changed to 0xFFFF: ignored; the original latched sequence continues.
